ps2_key_fifo: RTL and testbench
===============================

Name: ps2_key_fifo

Overview:
- Memory-mapped PS/2 keyboard event queue, directly upstream of the system CPU data mux.
- Replaces direct reads of the raw ps2_key bus: each toggle of ps2_key[10] captures one event into a FIFO.
- The Z80 drains events at its own pace, so rapid presses between polls are no longer lost.
- Sits in the 0x86xx input page; system decodes cs and routes dout into cpu_din.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO entries (default 16 entries).

Ports:
- clk_24  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ps2_key  input  11  [7:0] scancode, [8] extended, [9] pressed, [10] toggles on every press/release.
- cs  input  1  chip select from system address decode.
- cpu_addr  input  2  register select, cpu_addr[1:0].
- cpu_rd_n  input  1  Z80 read strobe, active low.
- cpu_wr_n  input  1  Z80 write strobe, active low.
- cpu_dout  input  8  CPU write data.
- dout  output  8  register read data, combinational from registers and cpu_addr.
- not_empty  output  1  high while count > 0.

Behaviour:
- Reset values:
  - FIFO pointers and count cleared; overflow flag cleared; not_empty = 0.
  - toggle_prev loaded with the current ps2_key[10], so reset never creates a spurious event.
- Capture:
  - On each edge where ps2_key[10] != toggle_prev, toggle_prev <= ps2_key[10] and a 10-bit entry {ps2_key[9:8], ps2_key[7:0]} is pushed.
  - count increments at that same edge; status reflects it from the next cycle.
- Register map, read (dout):
  - addr 0: status {not_empty, overflow, full, count[4:0]}. count saturates at 31 in the field if DEPTH_LOG2 > 4.
  - addr 1: head scancode [7:0] without popping.
  - addr 2: head flags {6'b0, pressed, extended} without popping.
  - addr 3: head scancode; pops the head.
  - Any read while the FIFO is empty returns 8'h00 for addr 1–3.
- Pop timing:
  - The pop occurs on the first clk_24 edge where cs, cpu_addr == 3 and cpu_rd_n are high while rd_n_prev was low, i.e. at the rising edge of rd_n.
  - Data therefore stays stable for the whole multi-cycle Z80 read.
  - A pop when the FIFO is empty is ignored.
- Write, addr 0: a write with cpu_dout[0] = 1 clears the FIFO (pointers and count) and the overflow flag, at the rising edge of wr_n (same edge detect as pop). Writes to other addresses are ignored.
- Full:
  - A push while full with no simultaneous pop is dropped, and the sticky overflow flag is set.
  - A push and a pop on the same edge both take effect: count unchanged, and the new entry is stored even when full.
- Empty: a simultaneous push and pop on an empty FIFO completes the push; the pop is ignored and count becomes 1.
- Clear vs push on the same edge: clear wins and the event is discarded, but toggle_prev still updates.
- Pointer arithmetic: DEPTH_LOG2-bit read/write pointers wrap modulo 2^DEPTH_LOG2; count is DEPTH_LOG2+1 bits wide.
- Storage: register array; no RAM read latency.
- Reset mid-operation: all queued events are discarded; the first post-reset event is the next toggle.

Optional Feature:
- PS2_KEY_FIFO_RELEASE_FILTER_EN
  - Defined: events with pressed = 0 are not pushed; toggle_prev still tracks ps2_key[10]; overflow is never set by a filtered event.
  - Undefined: all press and release events are queued.

Test Plan:
- Reset with ps2_key[10] = 1, hold, then read addr 0 -> 8'h00. No event after reset deasserts while ps2_key[10] stays at 1.
- Present scancode 8'h1C with pressed = 1, extended = 0, toggle 1->0, then read addr 0 -> 8'h81.
  - Read addr 2 -> 8'h02; read addr 1 -> 8'h1C with count unchanged.
  - Read addr 3 -> 8'h1C; addr 0 then -> 8'h00.
- Push 17 events with codes 8'h01..8'h11 at default depth, then read addr 0 -> 8'hF0 (not_empty, overflow, full, count = 16).
  - Sixteen addr 3 reads return 8'h01..8'h10 in order; 8'h11 was lost.
- Fill to 16 entries; toggle ps2_key on the exact edge the addr 3 read completes.
  - count stays 16, overflow stays 0, and the new code appears as the last entry.
- With 5 entries queued and overflow set, write 8'h01 to addr 0 -> addr 0 reads 8'h00. Then issue 3 pops -> all return 8'h00 and count stays 0.
- Build with PS2_KEY_FIFO_RELEASE_FILTER_EN defined; apply press 8'h29, release 8'h29, press 8'h1C -> count = 2, pops return 8'h29 then 8'h1C.

Source files
------------

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard event queue: captures each ps2_key[10] toggle into a FIFO drained by CPU reads.
// Optional PS2_KEY_FIFO_RELEASE_FILTER_EN: when defined, release events are not queued.
module ps2_key_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        clk_24,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        cs,
  input  logic [1:0]  cpu_addr,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  dout,
  output logic        not_empty
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          toggle_prev;
  logic          rd_n_prev;
  logic          wr_n_prev;

  logic          full;
  logic          empty;
  logic          push_req;
  logic          pop_req;
  logic          clr;
  logic          do_push;
  logic          do_pop;
  logic          ovf_set;
  logic [9:0]    head;
  logic [4:0]    count_field;
  logic [31:0]   count_ext;
  logic          unused;

  assign unused    = ^cpu_dout[7:1];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign not_empty = ~empty;
  assign head      = mem[rd_ptr];

  // Event detection, CPU strobe rising edges and push/pop arbitration
  always_comb begin
    push_req = (ps2_key[10] != toggle_prev);
`ifdef PS2_KEY_FIFO_RELEASE_FILTER_EN
    push_req = push_req & ps2_key[9];
`endif
    pop_req = cs && (cpu_addr == 2'd3) && cpu_rd_n && !rd_n_prev;
    clr     = cs && (cpu_addr == 2'd0) && cpu_wr_n && !wr_n_prev && cpu_dout[0];
    do_pop  = pop_req && !empty && !clr;
    do_push = push_req && (!full || do_pop) && !clr;
    ovf_set = push_req && full && !do_pop && !clr;
  end

  // Status count field saturates when the FIFO is deeper than 31 entries
  always_comb begin
    count_ext = 32'(count);
    if (count_ext > 32'd31) begin
      count_field = 5'd31;
    end else begin
      count_field = count_ext[4:0];
    end
  end

  always_comb begin
    dout = 8'h00;
    unique case (cpu_addr)
      2'd0: dout = {not_empty, overflow, full, count_field};
      2'd1: dout = empty ? 8'h00 : head[7:0];
      2'd2: dout = empty ? 8'h00 : {6'b0, head[9:8]};
      2'd3: dout = empty ? 8'h00 : head[7:0];
      default: dout = 8'h00;
    endcase
  end

  always_ff @(posedge clk_24) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      toggle_prev <= ps2_key[10];
      rd_n_prev   <= 1'b1;
      wr_n_prev   <= 1'b1;
    end else begin
      toggle_prev <= ps2_key[10];
      rd_n_prev   <= cpu_rd_n;
      wr_n_prev   <= cpu_wr_n;
      if (clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        unique case ({do_push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        if (ovf_set) overflow <= 1'b1;
      end
    end
  end

  // Storage has no reset; entries are only visible through count
  always_ff @(posedge clk_24) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= {ps2_key[9:8], ps2_key[7:0]};
    end
  end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed self-checking bench for ps2_key_fifo at default depth (16 entries).
module tb_ps2_key_fifo;

  logic        clk_24 = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        cs;
  logic [1:0]  cpu_addr;
  logic        cpu_rd_n;
  logic        cpu_wr_n;
  logic [7:0]  cpu_dout;
  logic [7:0]  dout;
  logic        not_empty;

  int n_checks = 0;
  int n_errors = 0;

  ps2_key_fifo dut (
    .clk_24    (clk_24),
    .reset     (reset),
    .ps2_key   (ps2_key),
    .cs        (cs),
    .cpu_addr  (cpu_addr),
    .cpu_rd_n  (cpu_rd_n),
    .cpu_wr_n  (cpu_wr_n),
    .cpu_dout  (cpu_dout),
    .dout      (dout),
    .not_empty (not_empty)
  );

  always #5 clk_24 = ~clk_24;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_24);
    #1;
  endtask

  task automatic send_key(input logic [7:0] code, input logic pressed, input logic ext);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    tick();
  endtask

  // Z80-like read: rd_n low for two cycles, data sampled while low, pop on rd_n rise
  task automatic cpu_read(input logic [1:0] addr, output logic [7:0] data);
    cs = 1'b1;
    cpu_addr = addr;
    cpu_rd_n = 1'b0;
    tick();
    tick();
    data = dout;
    cpu_rd_n = 1'b1;
    tick();
    cs = 1'b0;
    tick();
  endtask

  task automatic cpu_write(input logic [1:0] addr, input logic [7:0] data);
    cs = 1'b1;
    cpu_addr = addr;
    cpu_dout = data;
    cpu_wr_n = 1'b0;
    tick();
    tick();
    cpu_wr_n = 1'b1;
    tick();
    cs = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  logic [7:0] rd;

  initial begin
    reset    = 1'b1;
    ps2_key  = 11'h400;
    cs       = 1'b0;
    cpu_addr = 2'd0;
    cpu_rd_n = 1'b1;
    cpu_wr_n = 1'b1;
    cpu_dout = 8'h00;

    // Reset with toggle high: no spurious event
    do_reset();
    tick();
    tick();
    cpu_read(2'd0, rd); check("reset_status", rd, 8'h00);
    check("reset_not_empty", {7'b0, not_empty}, 8'h00);
    cpu_read(2'd1, rd); check("empty_peek", rd, 8'h00);

    // Single event 0x1C pressed, toggle 1->0
    send_key(8'h1C, 1'b1, 1'b0);
    cpu_read(2'd0, rd); check("one_status", rd, 8'h81);
    cpu_read(2'd2, rd); check("one_flags", rd, 8'h02);
    cpu_read(2'd1, rd); check("one_peek", rd, 8'h1C);
    cpu_read(2'd0, rd); check("peek_no_pop", rd, 8'h81);
    cpu_read(2'd3, rd); check("one_pop", rd, 8'h1C);
    cpu_read(2'd0, rd); check("one_drained", rd, 8'h00);
    cpu_read(2'd3, rd); check("empty_pop", rd, 8'h00);
    cpu_read(2'd0, rd); check("empty_pop_status", rd, 8'h00);

    // Extended release flags
    send_key(8'h75, 1'b0, 1'b1);
`ifndef PS2_KEY_FIFO_RELEASE_FILTER_EN
    cpu_read(2'd2, rd); check("ext_rel_flags", rd, 8'h01);
    cpu_read(2'd3, rd); check("ext_rel_pop", rd, 8'h75);
`endif
    cpu_read(2'd0, rd); check("ext_rel_drained", rd, 8'h00);

    // Overflow: 17 pushes, 17th dropped
    for (int i = 1; i <= 17; i++) send_key(8'(i), 1'b1, 1'b0);
    cpu_read(2'd0, rd); check("ovf_status", rd, 8'hF0);
    for (int i = 1; i <= 16; i++) begin
      cpu_read(2'd3, rd); check($sformatf("ovf_pop%0d", i), rd, 8'(i));
    end
    cpu_read(2'd0, rd); check("ovf_sticky", rd, 8'h40);
    cpu_write(2'd0, 8'h01);
    cpu_read(2'd0, rd); check("ovf_cleared", rd, 8'h00);

    // Push and pop on the same edge while full
    for (int i = 0; i < 16; i++) send_key(8'(8'h20 + i), 1'b1, 1'b0);
    cpu_read(2'd0, rd); check("full_status", rd, 8'hB0);
    cs = 1'b1;
    cpu_addr = 2'd3;
    cpu_rd_n = 1'b0;
    tick();
    tick();
    check("sim_pop_data", dout, 8'h20);
    cpu_rd_n = 1'b1;
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h55};
    tick();
    cs = 1'b0;
    tick();
    cpu_read(2'd0, rd); check("sim_status", rd, 8'hB0);
    for (int i = 1; i < 16; i++) begin
      cpu_read(2'd3, rd); check($sformatf("sim_pop%0d", i), rd, 8'(8'h20 + i));
    end
    cpu_read(2'd3, rd); check("sim_last", rd, 8'h55);
    cpu_read(2'd0, rd); check("sim_drained", rd, 8'h00);

    // Clear with 5 entries and overflow set
    for (int i = 1; i <= 17; i++) send_key(8'(8'h40 + i), 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) cpu_read(2'd3, rd);
    cpu_read(2'd0, rd); check("five_ovf_status", rd, 8'hC5);
    cpu_read(2'd1, rd); check("five_head", rd, 8'h4C);
    cpu_write(2'd0, 8'h00);
    cpu_read(2'd0, rd); check("wr_bit0_low", rd, 8'hC5);
    cpu_write(2'd1, 8'h01);
    cpu_read(2'd0, rd); check("wr_other_addr", rd, 8'hC5);
    cpu_write(2'd0, 8'h01);
    cpu_read(2'd0, rd); check("clear_status", rd, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cpu_read(2'd3, rd); check($sformatf("clear_pop%0d", i), rd, 8'h00);
    end
    cpu_read(2'd0, rd); check("clear_count", rd, 8'h00);

    // Clear and push on the same edge: clear wins, no late event
    send_key(8'h33, 1'b1, 1'b0);
    cs = 1'b1;
    cpu_addr = 2'd0;
    cpu_dout = 8'h01;
    cpu_wr_n = 1'b0;
    tick();
    tick();
    cpu_wr_n = 1'b1;
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h34};
    tick();
    cs = 1'b0;
    tick();
    tick();
    cpu_read(2'd0, rd); check("clr_vs_push", rd, 8'h00);

    // Reset mid-operation discards queue
    send_key(8'h5A, 1'b1, 1'b0);
    send_key(8'h5B, 1'b1, 1'b0);
    cpu_read(2'd0, rd); check("pre_reset", rd, 8'h82);
    do_reset();
    tick();
    cpu_read(2'd0, rd); check("post_reset", rd, 8'h00);
    send_key(8'h66, 1'b1, 1'b0);
    cpu_read(2'd3, rd); check("post_reset_event", rd, 8'h66);

    // Press / release / press
    send_key(8'h29, 1'b1, 1'b0);
    send_key(8'h29, 1'b0, 1'b0);
    send_key(8'h1C, 1'b1, 1'b0);
`ifdef PS2_KEY_FIFO_RELEASE_FILTER_EN
    cpu_read(2'd0, rd); check("filt_status", rd, 8'h82);
    cpu_read(2'd3, rd); check("filt_pop0", rd, 8'h29);
    cpu_read(2'd3, rd); check("filt_pop1", rd, 8'h1C);
`else
    cpu_read(2'd0, rd); check("prp_status", rd, 8'h83);
    cpu_read(2'd3, rd); check("prp_pop0", rd, 8'h29);
    cpu_read(2'd2, rd); check("prp_rel_flags", rd, 8'h00);
    cpu_read(2'd3, rd); check("prp_pop1", rd, 8'h29);
    cpu_read(2'd3, rd); check("prp_pop2", rd, 8'h1C);
`endif
    cpu_read(2'd0, rd); check("final_empty", rd, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
